// File: rtl/stinner_pkg.sv
// Shared blitter definitions: inner-loop state encoding, count-width default, FSM helpers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package stinner_pkg;

  localparam int CNTW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SRCR = 2'd1,
    DSTR = 2'd2,
    DSTW = 2'd3
  } inner_st_e;

  // State plus its request decodes, registered together so the requests
  // change on the same edge as the state.
  typedef struct packed {
    inner_st_e st;
    logic      srcrd;
    logic      dstrd;
    logic      dstwr;
  } fsm_out_t;

  // First bus cycle of a pixel, chosen from the command bits.
  function automatic inner_st_e first_pixel(input logic srcen, input logic dsten);
    if (srcen)      return SRCR;
    else if (dsten) return DSTR;
    else            return DSTW;
  endfunction

  function automatic fsm_out_t enter(input inner_st_e st);
    fsm_out_t o;
    o.st    = st;
    o.srcrd = (st == SRCR);
    o.dstrd = (st == DSTR);
    o.dstwr = (st == DSTW);
    return o;
  endfunction

endpackage

// File: rtl/stinner_if.sv
// Inner-loop control bundle between the outer loop / bus side and stinner.
// Latency: none (wires only).
// Backpressure: BUSACK holds each request until the bus cycle completes.
// Ports: master = outer loop + bus model side, slave = stinner.
interface stinner_if #(
  parameter int CNTW = 8
);
  logic            INLP;
  logic            LDICNTL;
  logic [CNTW-1:0] INCNT;
  logic            SRCEN;
  logic            DSTEN;
  logic            STOP;
  logic            BUSACK;
  logic            IQUIET;
  logic            SRCRD;
  logic            DSTRD;
  logic            DSTWR;
  logic            SINC;
  logic            DINC;
  logic [CNTW:0]   ICNT;
  logic            STOPPED;

  modport master (
    output INLP, LDICNTL, INCNT, SRCEN, DSTEN, STOP, BUSACK,
    input  IQUIET, SRCRD, DSTRD, DSTWR, SINC, DINC, ICNT, STOPPED
  );

  modport slave (
    input  INLP, LDICNTL, INCNT, SRCEN, DSTEN, STOP, BUSACK,
    output IQUIET, SRCRD, DSTRD, DSTWR, SINC, DINC, ICNT, STOPPED
  );
endinterface

// File: rtl/stinner_cnt.sv
// Loadable down-counter with one-detect; a loaded 0 means 2^W.
// Latency: load/clear/decrement visible one cycle after the strobe.
// Backpressure: none; load beats clear beats decrement, never wraps below 0.
// Ports: clk, rst (sync, active-high), ld/ld_val, clr, dec -> cnt, is_one.
module stinner_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         clr,
  input  logic         dec,
  output logic [W:0]   cnt,
  output logic         is_one
);

  logic is_zero;

  assign is_zero = (cnt == '0);
  assign is_one  = (cnt == {{W{1'b0}}, 1'b1});

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (ld) begin
      // The extra MSB holds the full-length 2^W case.
      cnt <= (ld_val == '0) ? {1'b1, {W{1'b0}}} : {1'b0, ld_val};
    end else if (clr) begin
      cnt <= '0;
    end else if (dec && !is_zero) begin
      cnt <= cnt - {{W{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/stinner.sv
// Blitter inner-loop FSM: per pixel source read, dest read, dest write with address steps.
// Latency: first request 1 cycle after INLP&ARMED; 1 cycle per bus cycle at zero wait.
// Backpressure: each request is held until BUSACK; SINC/DINC pulse the cycle after the ack.
// Ports: CCLK, SRESET (sync, active-high), bus = stinner_if.slave.
module stinner
  import stinner_pkg::*;
#(
  parameter int CNTW = CNTW_DEF
) (
  input  logic     CCLK,
  input  logic     SRESET,
  stinner_if.slave bus
);

  fsm_out_t fsm_q;
  logic     armed;
  logic     stopped_q;
  logic     sinc_q;
  logic     dinc_q;
  logic     load;
  logic     cnt_dec;
  logic     cnt_clr;
  logic     cnt_is_one;

  assign load    = ~bus.LDICNTL;
  assign cnt_dec = (fsm_q.st == DSTW) && bus.BUSACK;
  assign cnt_clr = (fsm_q.st == DSTR) && bus.BUSACK && bus.STOP;

  stinner_cnt #(.W(CNTW)) u_cnt (
    .clk    (CCLK),
    .rst    (SRESET),
    .ld     (load),
    .ld_val (bus.INCNT),
    .clr    (cnt_clr),
    .dec    (cnt_dec),
    .cnt    (bus.ICNT),
    .is_one (cnt_is_one)
  );

  always_ff @(posedge CCLK) begin
    if (SRESET) begin
      fsm_q     <= enter(IDLE);
      armed     <= 1'b0;
      stopped_q <= 1'b0;
      sinc_q    <= 1'b0;
      dinc_q    <= 1'b0;
    end else begin
      sinc_q <= 1'b0;
      dinc_q <= 1'b0;
      case (fsm_q.st)
        IDLE: begin
          if (bus.INLP && armed) begin
            fsm_q <= enter(first_pixel(bus.SRCEN, bus.DSTEN));
            armed <= 1'b0;
          end
        end
        SRCR: begin
          if (bus.BUSACK) begin
            sinc_q <= 1'b1;
            fsm_q  <= enter(bus.DSTEN ? DSTR : DSTW);
          end
        end
        DSTR: begin
          if (bus.BUSACK) begin
            if (bus.STOP) begin
              // Collision: abandon the run without writing this pixel.
              stopped_q <= 1'b1;
              fsm_q     <= enter(IDLE);
            end else begin
              fsm_q <= enter(DSTW);
            end
          end
        end
        DSTW: begin
          if (bus.BUSACK) begin
            dinc_q <= 1'b1;
            // Command bits are re-sampled at every pixel boundary.
            fsm_q  <= enter(cnt_is_one ? IDLE : first_pixel(bus.SRCEN, bus.DSTEN));
          end
        end
        default: fsm_q <= enter(IDLE);
      endcase
      // A load re-arms even if it coincides with a start.
      if (load) begin
        armed     <= 1'b1;
        stopped_q <= 1'b0;
      end
    end
  end

  // Drops in the same cycle INLP rises with ARMED set, so the outer loop
  // never samples a stale "done" before the first request appears.
  assign bus.IQUIET  = (fsm_q.st == IDLE) && !(bus.INLP && armed);
  assign bus.SRCRD   = fsm_q.srcrd;
  assign bus.DSTRD   = fsm_q.dstrd;
  assign bus.DSTWR   = fsm_q.dstwr;
  assign bus.SINC    = sinc_q;
  assign bus.DINC    = dinc_q;
  assign bus.STOPPED = stopped_q;

endmodule

// File: tb/tb_stinner.sv
// Directed self-checking bench for stinner.
// Latency: inputs driven 1 time unit after the rising edge, outputs checked 1 unit later.
// Backpressure: BUSACK driven directly by the bench.
module tb_stinner;

  logic CCLK;
  logic SRESET;
  int   vectors;
  int   miscompares;

  stinner_if #(.CNTW(8)) bus ();

  stinner #(.CNTW(8)) dut (
    .CCLK   (CCLK),
    .SRESET (SRESET),
    .bus    (bus.slave)
  );

  logic [2:0] reqs;
  assign reqs = {bus.SRCRD, bus.DSTRD, bus.DSTWR};

  initial CCLK = 1'b0;
  always #5 CCLK = ~CCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CCLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [2:0] e_req;
    int sinc_n;
    int dinc_n;
    vectors     = 0;
    miscompares = 0;
    SRESET      = 1'b1;
    bus.INLP    = 1'b0;
    bus.LDICNTL = 1'b1;
    bus.INCNT   = 8'd0;
    bus.SRCEN   = 1'b0;
    bus.DSTEN   = 1'b0;
    bus.STOP    = 1'b0;
    bus.BUSACK  = 1'b0;
    nxt();
    nxt();
    SRESET = 1'b0;
    settle();

    // Reset state.
    check("rst_iquiet",  32'(bus.IQUIET), 32'd1);
    check("rst_icnt",    32'(bus.ICNT), 32'd0);
    check("rst_reqs",    32'(reqs), 32'd0);
    check("rst_incs",    32'({bus.SINC, bus.DINC}), 32'd0);
    check("rst_stopped", 32'(bus.STOPPED), 32'd0);

    // Three full pixels, zero wait.
    bus.LDICNTL = 1'b0;
    bus.INCNT   = 8'd3;
    bus.SRCEN   = 1'b1;
    bus.DSTEN   = 1'b1;
    bus.BUSACK  = 1'b1;
    nxt();
    bus.LDICNTL = 1'b1;
    settle();
    check("t1_load_icnt",   32'(bus.ICNT), 32'd3);
    check("t1_idle_iquiet", 32'(bus.IQUIET), 32'd1);
    bus.INLP = 1'b1;
    settle();
    check("t1_iquiet_drop", 32'(bus.IQUIET), 32'd0);
    sinc_n = 0;
    dinc_n = 0;
    for (int k = 0; k < 9; k++) begin
      nxt();
      e_req = 3'b100 >> (k % 3);
      check("t1_reqs",   32'(reqs), 32'(e_req));
      check("t1_sinc",   32'(bus.SINC), 32'((k % 3) == 1));
      check("t1_dinc",   32'(bus.DINC), 32'(((k % 3) == 0) && (k > 0)));
      check("t1_icnt",   32'(bus.ICNT), 32'(3 - k / 3));
      check("t1_iquiet", 32'(bus.IQUIET), 32'd0);
      sinc_n += int'(bus.SINC);
      dinc_n += int'(bus.DINC);
    end
    nxt();
    dinc_n += int'(bus.DINC);
    check("t1_end_iquiet", 32'(bus.IQUIET), 32'd1);
    check("t1_end_reqs",   32'(reqs), 32'd0);
    check("t1_end_icnt",   32'(bus.ICNT), 32'd0);
    check("t1_sinc_total", 32'(sinc_n), 32'd3);
    check("t1_dinc_total", 32'(dinc_n), 32'd3);
    bus.INLP = 1'b0;

    // Full-length run: INCNT=0 means 256 write-only pixels.
    bus.LDICNTL = 1'b0;
    bus.INCNT   = 8'd0;
    bus.SRCEN   = 1'b0;
    bus.DSTEN   = 1'b0;
    nxt();
    bus.LDICNTL = 1'b1;
    settle();
    check("t2_load_icnt", 32'(bus.ICNT), 32'd256);
    bus.INLP = 1'b1;
    for (int k = 0; k < 256; k++) begin
      nxt();
      check("t2_wr_icnt", 32'({bus.DSTWR, bus.ICNT}), 32'({1'b1, 9'(256 - k)}));
    end
    nxt();
    check("t2_end_reqs",   32'(reqs), 32'd0);
    check("t2_end_icnt",   32'(bus.ICNT), 32'd0);
    check("t2_end_iquiet", 32'(bus.IQUIET), 32'd1);
    bus.INLP = 1'b0;

    // Collision stop at the first destination read.
    bus.LDICNTL = 1'b0;
    bus.INCNT   = 8'd2;
    bus.DSTEN   = 1'b1;
    bus.STOP    = 1'b1;
    nxt();
    bus.LDICNTL = 1'b1;
    bus.INLP    = 1'b1;
    nxt();
    check("t3_dstrd", 32'(reqs), 32'b010);
    nxt();
    check("t3_no_wr",  32'(reqs), 32'd0);
    check("t3_stop",   32'(bus.STOPPED), 32'd1);
    check("t3_icnt",   32'(bus.ICNT), 32'd0);
    check("t3_iquiet", 32'(bus.IQUIET), 32'd1);
    check("t3_dinc",   32'(bus.DINC), 32'd0);
    bus.STOP = 1'b0;
    bus.INLP = 1'b0;

    // One pixel with 4 wait cycles in every bus cycle.
    bus.LDICNTL = 1'b0;
    bus.INCNT   = 8'd1;
    bus.SRCEN   = 1'b1;
    bus.DSTEN   = 1'b1;
    bus.BUSACK  = 1'b0;
    nxt();
    bus.LDICNTL = 1'b1;
    settle();
    check("t4_stopped_clr", 32'(bus.STOPPED), 32'd0);
    bus.INLP = 1'b1;
    nxt();
    for (int s = 0; s < 3; s++) begin
      for (int h = 0; h < 5; h++) begin
        bus.BUSACK = (h == 4);
        settle();
        e_req = 3'b100 >> s;
        check("t4_hold", 32'(reqs), 32'(e_req));
        check("t4_sinc", 32'(bus.SINC), 32'((s == 1) && (h == 0)));
        check("t4_dinc", 32'(bus.DINC), 32'd0);
        nxt();
      end
    end
    bus.BUSACK = 1'b0;
    settle();
    check("t4_end_dinc",   32'(bus.DINC), 32'd1);
    check("t4_end_iquiet", 32'(bus.IQUIET), 32'd1);
    nxt();
    check("t4_dinc_once",  32'(bus.DINC), 32'd0);

    // INLP without a load: never starts.
    SRESET = 1'b1;
    nxt();
    SRESET     = 1'b0;
    bus.INLP   = 1'b1;
    bus.BUSACK = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      check("t5_quiet", 32'({bus.IQUIET, reqs}), 32'b1000);
      nxt();
    end

    // Reset while a write is pending, with load and ack also active.
    bus.LDICNTL = 1'b0;
    bus.INCNT   = 8'd5;
    bus.SRCEN   = 1'b0;
    bus.DSTEN   = 1'b0;
    bus.BUSACK  = 1'b0;
    nxt();
    bus.LDICNTL = 1'b1;
    nxt();
    nxt();
    check("t6_pending", 32'(reqs), 32'b001);
    SRESET      = 1'b1;
    bus.LDICNTL = 1'b0;
    bus.BUSACK  = 1'b1;
    nxt();
    check("t6_reqs",    32'(reqs), 32'd0);
    check("t6_incs",    32'({bus.SINC, bus.DINC}), 32'd0);
    check("t6_icnt",    32'(bus.ICNT), 32'd0);
    check("t6_stopped", 32'(bus.STOPPED), 32'd0);
    check("t6_iquiet",  32'(bus.IQUIET), 32'd1);
    SRESET      = 1'b0;
    bus.LDICNTL = 1'b1;
    bus.BUSACK  = 1'b0;
    nxt();
    check("t6_unarmed", 32'({bus.IQUIET, reqs}), 32'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
